// File: rtl/amo_pkg.sv
// Shared AMO definitions: funct5 encodings, reservation granule helpers and the
// reservation record used by both amo_unit and reservation_set.
package amo_pkg;

  localparam logic [4:0] AMO_FUNCT5_ADD  = 5'b00000;
  localparam logic [4:0] AMO_FUNCT5_SWAP = 5'b00001;
  localparam logic [4:0] AMO_FUNCT5_LR   = 5'b00010;
  localparam logic [4:0] AMO_FUNCT5_SC   = 5'b00011;
  localparam logic [4:0] AMO_FUNCT5_XOR  = 5'b00100;
  localparam logic [4:0] AMO_FUNCT5_OR   = 5'b01000;
  localparam logic [4:0] AMO_FUNCT5_AND  = 5'b01100;
  localparam logic [4:0] AMO_FUNCT5_MIN  = 5'b10000;
  localparam logic [4:0] AMO_FUNCT5_MAX  = 5'b10100;
  localparam logic [4:0] AMO_FUNCT5_MINU = 5'b11000;
  localparam logic [4:0] AMO_FUNCT5_MAXU = 5'b11100;

  // Widest address any client may use; narrower clients use the low bits.
  localparam int unsigned RESV_ADDR_W = 64;

  function automatic int unsigned granule_off_w(input int unsigned granule_bytes);
    return $clog2(granule_bytes);
  endfunction

  localparam int unsigned GRANULE_OFF_W = granule_off_w(64);

  typedef struct packed {
    logic                   valid;
    logic [RESV_ADDR_W-1:0] addr;
    logic                   is_word;
  } resv_t;

  typedef enum logic {
    RESV_EMPTY = 1'b0,
    RESV_HELD  = 1'b1
  } resv_state_e;

endpackage

// File: rtl/reservation_set.sv
// Single LR/SC reservation: set by an aligned LR, killed by SC, snoop hits on the
// reserved granule, clear pulses or timeout. SC verdict is combinational.
module reservation_set
  import amo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned GRANULE_BYTES  = 64,
  parameter int unsigned TIMEOUT_CYCLES = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lr_valid,
  input  logic [ADDR_WIDTH-1:0] lr_addr,
  input  logic                  lr_is_word,
  input  logic                  sc_valid,
  input  logic [ADDR_WIDTH-1:0] sc_addr,
  input  logic                  sc_is_word,
  output logic                  sc_success,
  input  logic                  snoop_valid,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic                  clear,
  output logic                  resv_valid,
  output logic [ADDR_WIDTH-1:0] resv_addr
);

  localparam int unsigned OFF_W = granule_off_w(GRANULE_BYTES);
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

  resv_t              resv_q, resv_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  resv_state_e        state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr;

  logic lr_aligned;
  logic lr_snooped;
  logic snoop_hit;
  logic timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resv_q <= '0;
      cnt_q  <= '0;
    end else begin
      resv_q <= resv_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    state_q     = resv_q.valid ? RESV_HELD : RESV_EMPTY;
    cur_addr    = resv_q.addr[ADDR_WIDTH-1:0];
    lr_aligned  = lr_is_word ? (lr_addr[1:0] == 2'b00) : (lr_addr[2:0] == 3'b000);
    lr_snooped  = snoop_valid &&
                  (snoop_addr[ADDR_WIDTH-1:OFF_W] == lr_addr[ADDR_WIDTH-1:OFF_W]);
    snoop_hit   = snoop_valid && (state_q == RESV_HELD) &&
                  (snoop_addr[ADDR_WIDTH-1:OFF_W] == cur_addr[ADDR_WIDTH-1:OFF_W]);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == RESV_HELD) && (cnt_q == CNT_W'(1));
  end

  // A snoop on the granule being reserved by a concurrent LR wins over the LR.
  always_comb begin
    state_d = state_q;
    resv_d  = resv_q;
    cnt_d   = cnt_q;
    if (state_q == RESV_HELD && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (clear) begin
      state_d = RESV_EMPTY;
    end else if (lr_valid) begin
      if (lr_aligned && !lr_snooped) begin
        state_d        = RESV_HELD;
        resv_d.addr    = RESV_ADDR_W'(lr_addr);
        resv_d.is_word = lr_is_word;
        cnt_d          = CNT_LOAD;
      end else begin
        state_d = RESV_EMPTY;
      end
    end else if (sc_valid || snoop_hit || timeout_hit) begin
      state_d = RESV_EMPTY;
    end
    resv_d.valid = (state_d == RESV_HELD);
  end

  always_comb begin
    resv_valid = resv_q.valid;
    resv_addr  = cur_addr;
    sc_success = rst_n && sc_valid && (state_q == RESV_HELD) &&
                 (sc_addr == cur_addr) && (sc_is_word == resv_q.is_word) &&
                 !snoop_hit && !clear;
  end

endmodule

// File: tb/tb_reservation_set.sv
// Bench for reservation_set: directed LR/SC scenarios plus random traffic checked
// against a deadline-based reference model of the reservation.
module tb_reservation_set;

  localparam int unsigned    T = 4;
  localparam longint unsigned G = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lr_valid, lr_is_word, sc_valid, sc_is_word, snoop_valid, clear;
  logic [63:0] lr_addr, sc_addr, snoop_addr;
  logic        sc_success, resv_valid;
  logic [63:0] resv_addr;

  always #5 clk = ~clk;

  reservation_set #(
    .ADDR_WIDTH(64),
    .GRANULE_BYTES(64),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lr_valid(lr_valid), .lr_addr(lr_addr), .lr_is_word(lr_is_word),
    .sc_valid(sc_valid), .sc_addr(sc_addr), .sc_is_word(sc_is_word),
    .sc_success(sc_success),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .clear(clear),
    .resv_valid(resv_valid), .resv_addr(resv_addr)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  // Reference: reservation is live while held and the current cycle precedes its deadline.
  bit          m_held = 1'b0;
  logic [63:0] m_addr = '0;
  bit          m_word = 1'b0;
  int unsigned m_exp  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit same_granule(input logic [63:0] a, input logic [63:0] b);
    return (a / G) == (b / G);
  endfunction

  function automatic bit m_valid();
    return m_held && (cyc < m_exp);
  endfunction

  function automatic bit m_sc_expect();
    bit killed;
    killed = snoop_valid && same_granule(snoop_addr, m_addr);
    return rst_n && sc_valid && m_valid() && (sc_addr == m_addr) &&
           (sc_is_word == m_word) && !killed && !clear;
  endfunction

  task automatic idle();
    rst_n = 1'b1; clear = 1'b0;
    lr_valid = 1'b0; lr_addr = '0; lr_is_word = 1'b0;
    sc_valid = 1'b0; sc_addr = '0; sc_is_word = 1'b0;
    snoop_valid = 1'b0; snoop_addr = '0;
  endtask

  task automatic settle();
    #4;
    check("resv_valid", {63'd0, resv_valid}, {63'd0, m_valid()});
    check("resv_addr", resv_addr, m_addr);
    if (sc_valid) check("sc_success", {63'd0, sc_success}, {63'd0, m_sc_expect()});
  endtask

  task automatic advance();
    bit aligned;
    @(posedge clk);
    if (!rst_n) begin
      m_held = 1'b0; m_addr = '0; m_word = 1'b0;
    end else if (clear) begin
      m_held = 1'b0;
    end else if (lr_valid) begin
      aligned = (lr_addr % (lr_is_word ? 64'd4 : 64'd8)) == 0;
      if (aligned && !(snoop_valid && same_granule(snoop_addr, lr_addr))) begin
        m_held = 1'b1; m_addr = lr_addr; m_word = lr_is_word; m_exp = cyc + 1 + T;
      end else begin
        m_held = 1'b0;
      end
    end else if (sc_valid || (snoop_valid && m_valid() && same_granule(snoop_addr, m_addr))) begin
      m_held = 1'b0;
    end
    cyc++;
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic lr(input logic [63:0] a, input bit w);
    lr_valid = 1'b1; lr_addr = a; lr_is_word = w;
  endtask

  task automatic sc(input logic [63:0] a, input bit w);
    sc_valid = 1'b1; sc_addr = a; sc_is_word = w;
  endtask

  task automatic flush();
    idle(); clear = 1'b1; step(); idle();
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    a = 64'h8000 + 64'($urandom_range(0, 3)) * G;
    if ($urandom_range(0, 3) != 0) a = a + 64'($urandom_range(0, 7)) * 8;
    else a = a + 64'($urandom_range(0, 63));
    return a;
  endfunction

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // Reset with concurrent LR/SC: no verdict and the LR is discarded.
    lr(64'h1000, 1'b0); sc(64'h1000, 1'b0);
    settle();
    check("rst_sc", {63'd0, sc_success}, 64'd0);
    advance();
    idle();
    settle();
    check("rst_lr_discard", {63'd0, resv_valid}, 64'd0);
    check("rst_addr", resv_addr, 64'd0);
    advance();

    // Basic LR.D / SC.D
    lr(64'h1000, 1'b0); step(); idle(); step();
    sc(64'h1000, 1'b0); settle();
    check("basic_sc", {63'd0, sc_success}, 64'd1);
    advance(); idle(); settle();
    check("basic_sc_clears", {63'd0, resv_valid}, 64'd0);
    advance();

    // Snoop kill within the granule
    lr(64'h2004, 1'b1); step(); idle();
    snoop_valid = 1'b1; snoop_addr = 64'h2038; step(); idle();
    sc(64'h2004, 1'b1); settle();
    check("snoop_kill", {63'd0, sc_success}, 64'd0);
    advance(); idle();

    // Snoop in the neighbouring granule leaves the reservation alone
    lr(64'h2004, 1'b1); step(); idle();
    snoop_valid = 1'b1; snoop_addr = 64'h2040; step(); idle();
    sc(64'h2004, 1'b1); settle();
    check("snoop_miss", {63'd0, sc_success}, 64'd1);
    advance(); idle();

    // Width, address and alignment mismatches
    lr(64'h3000, 1'b0); step(); idle(); sc(64'h3000, 1'b1); settle();
    check("width_mismatch", {63'd0, sc_success}, 64'd0);
    advance(); idle();
    lr(64'h3000, 1'b0); step(); idle(); sc(64'h3008, 1'b0); settle();
    check("addr_mismatch", {63'd0, sc_success}, 64'd0);
    advance(); idle();
    lr(64'h3002, 1'b1); step(); idle(); sc(64'h3002, 1'b1); settle();
    check("misaligned_lr", {63'd0, sc_success}, 64'd0);
    advance(); idle();

    // Timeout: live for exactly T cycles after the LR cycle
    lr(64'h5000, 1'b0); step(); idle();
    for (int i = 1; i <= int'(T); i++) begin
      settle();
      check("timeout_live", {63'd0, resv_valid}, 64'd1);
      advance();
    end
    sc(64'h5000, 1'b0); settle();
    check("timeout_dead", {63'd0, resv_valid}, 64'd0);
    check("timeout_sc", {63'd0, sc_success}, 64'd0);
    advance(); idle();

    // Simultaneous events
    lr(64'h6000, 1'b0); clear = 1'b1; step(); idle(); settle();
    check("clear_beats_lr", {63'd0, resv_valid}, 64'd0);
    advance();
    lr(64'h1000, 1'b0); step(); idle();
    lr(64'h4000, 1'b0); sc(64'h1000, 1'b0); settle();
    check("lr_sc_old_resv", {63'd0, sc_success}, 64'd1);
    advance(); idle(); settle();
    check("lr_sc_new_addr", resv_addr, 64'h4000);
    check("lr_sc_new_valid", {63'd0, resv_valid}, 64'd1);
    advance();
    lr(64'h7008, 1'b0); snoop_valid = 1'b1; snoop_addr = 64'h7030; step(); idle(); settle();
    check("lr_snoop_same", {63'd0, resv_valid}, 64'd0);
    advance();
    lr(64'h1000, 1'b0); step(); idle(); rst_n = 1'b0; step(); idle(); settle();
    check("rst_held", {63'd0, resv_valid}, 64'd0);
    check("rst_held_addr", resv_addr, 64'd0);
    advance();
    flush();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 63) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 15) == 0) clear = 1'b1;
      if ($urandom_range(0, 3) == 0) lr(rand_addr(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) sc(m_addr, ($urandom_range(0, 9) < 7) ? m_word : ~m_word);
        else sc(rand_addr(), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 5) == 0) begin
        snoop_valid = 1'b1; snoop_addr = rand_addr();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
